// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry, address width and arbiter FSM state type
package fb_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W = 19;
  localparam int PIXEL_W = 24;
  typedef enum logic {IDLE, CLEAR} fb_state_t;
endpackage

// File: rtl/framebuffer_arbiter_if.sv
// framebuffer_arbiter_if: scan-out, draw, clear and memory signals of the framebuffer arbiter
// slave: arbiter view (scan-out/draw/clear requests and read data in; pixels, ready, busy, memory port out)
// master: environment view (mirror of slave)
interface framebuffer_arbiter_if #(
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int PIXEL_W = fb_pkg::PIXEL_W
);
  logic vga_req_i;
  logic [9:0] vga_x_i;
  logic [9:0] vga_y_i;
  logic vga_valid_o;
  logic [7:0] vga_red_o;
  logic [7:0] vga_green_o;
  logic [7:0] vga_blue_o;
  logic wr_valid_i;
  logic wr_ready_o;
  logic [9:0] wr_x_i;
  logic [9:0] wr_y_i;
  logic [PIXEL_W-1:0] wr_color_i;
  logic clear_i;
  logic [PIXEL_W-1:0] clear_color_i;
  logic clear_busy_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic mem_we_o;
  logic [PIXEL_W-1:0] mem_wdata_o;
  logic [PIXEL_W-1:0] mem_rdata_i;
  modport slave (
    input vga_req_i, vga_x_i, vga_y_i, wr_valid_i, wr_x_i, wr_y_i, wr_color_i,
    input clear_i, clear_color_i, mem_rdata_i,
    output vga_valid_o, vga_red_o, vga_green_o, vga_blue_o, wr_ready_o, clear_busy_o,
    output mem_addr_o, mem_we_o, mem_wdata_o
  );
  modport master (
    output vga_req_i, vga_x_i, vga_y_i, wr_valid_i, wr_x_i, wr_y_i, wr_color_i,
    output clear_i, clear_color_i, mem_rdata_i,
    input vga_valid_o, vga_red_o, vga_green_o, vga_blue_o, wr_ready_o, clear_busy_o,
    input mem_addr_o, mem_we_o, mem_wdata_o
  );
endinterface

// File: rtl/fb_addr_calc.sv
// fb_addr_calc: combinational pixel (x,y) to framebuffer word address plus range check
// x, y in: pixel coordinate; addr out: y*640+x; in_range out: x<H_ACTIVE && y<V_ACTIVE
module fb_addr_calc #(
  parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
  parameter int V_ACTIVE = fb_pkg::V_ACTIVE,
  parameter int ADDR_W = fb_pkg::ADDR_W
) (
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);
  localparam logic [9:0] X_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] Y_LIM = 10'(V_ACTIVE);
  // y*640 as two shifts: 512 + 128
  assign addr = (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7) + ADDR_W'(x);
  assign in_range = x < X_LIM && y < Y_LIM;
endmodule

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: single-port framebuffer arbiter for scan-out reads, clear sweep and draw writes
// clock_i/reset_i: clock and async active-low reset
// fb (slave): scan-out fetch (3-cycle latency), draw write handshake, clear command/busy, memory port
module framebuffer_arbiter #(
  parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
  parameter int V_ACTIVE = fb_pkg::V_ACTIVE,
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int PIXEL_W = fb_pkg::PIXEL_W
) (
  input logic clock_i,
  input logic reset_i,
  framebuffer_arbiter_if.slave fb
);
  import fb_pkg::*;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  fb_state_t state, state_nxt;
  logic [ADDR_W-1:0] clear_addr, clear_addr_nxt, vga_addr, wr_addr, addr_q, addr_nxt;
  logic [PIXEL_W-1:0] clear_color, clear_color_nxt, wdata_q, wdata_nxt, rgb_q;
  logic vga_in, wr_in, we_q, we_nxt, wr_ready;
  logic p1_valid, p1_in, p2_valid, p2_in, valid_q;
  fb_addr_calc #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .ADDR_W(ADDR_W)) u_vga_addr (
    .x(fb.vga_x_i), .y(fb.vga_y_i), .addr(vga_addr), .in_range(vga_in)
  );
  fb_addr_calc #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .ADDR_W(ADDR_W)) u_wr_addr (
    .x(fb.wr_x_i), .y(fb.wr_y_i), .addr(wr_addr), .in_range(wr_in)
  );
  // reset_i is in the term so ready drops combinationally while reset is held
  assign wr_ready = state == IDLE && !fb.vga_req_i && reset_i;
  // one memory slot per cycle: scan-out, then clear sweep, then draw write
  always_comb begin
    state_nxt = state;
    clear_addr_nxt = clear_addr;
    clear_color_nxt = clear_color;
    addr_nxt = addr_q;
    we_nxt = 1'b0;
    wdata_nxt = wdata_q;
    if (fb.vga_req_i) begin
      addr_nxt = vga_addr;
    end else if (state == CLEAR) begin
      addr_nxt = clear_addr;
      we_nxt = 1'b1;
      wdata_nxt = clear_color;
      clear_addr_nxt = clear_addr + 1'b1;
      state_nxt = clear_addr == LAST ? IDLE : CLEAR;
    end else if (fb.wr_valid_i && wr_ready && wr_in) begin
      addr_nxt = wr_addr;
      we_nxt = 1'b1;
      wdata_nxt = fb.wr_color_i;
    end
    // a clear command may coincide with an accepted draw write; the sweep starts next cycle
    if (state == IDLE && fb.clear_i) begin
      state_nxt = CLEAR;
      clear_addr_nxt = '0;
      clear_color_nxt = fb.clear_color_i;
    end
  end
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= IDLE;
      clear_addr <= '0;
      clear_color <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      p1_valid <= 1'b0;
      p1_in <= 1'b0;
      p2_valid <= 1'b0;
      p2_in <= 1'b0;
      valid_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      state <= state_nxt;
      clear_addr <= clear_addr_nxt;
      clear_color <= clear_color_nxt;
      addr_q <= addr_nxt;
      we_q <= we_nxt;
      wdata_q <= wdata_nxt;
      p1_valid <= fb.vga_req_i;
      p1_in <= vga_in;
      p2_valid <= p1_valid;
      p2_in <= p1_in;
      valid_q <= p2_valid;
      rgb_q <= p2_in ? fb.mem_rdata_i : '0;
    end
  end
  assign fb.wr_ready_o = wr_ready;
  assign fb.clear_busy_o = state == CLEAR;
  assign fb.mem_addr_o = addr_q;
  assign fb.mem_we_o = we_q;
  assign fb.mem_wdata_o = wdata_q;
  assign fb.vga_valid_o = valid_q;
  assign fb.vga_red_o = rgb_q[23:16];
  assign fb.vga_green_o = rgb_q[15:8];
  assign fb.vga_blue_o = rgb_q[7:0];
endmodule
